// File: rtl/adpll_pkg.sv
// Shared types and defaults for the ADPLL acquisition/lock sequencer.
package adpll_pkg;

    localparam int DEF_CODE_W    = 7;
    localparam int DEF_INIT_CODE = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        TRACK  = 2'd2,
        LOCKED = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        UP   = 2'd1,
        DN   = 2'd2
    } decision_e;

    // Both detector outputs high is treated as no information.
    function automatic decision_e decode(input logic up, input logic dn);
        decision_e d;
        case ({up, dn})
            2'b10:   d = UP;
            2'b01:   d = DN;
            default: d = NONE;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/adpll_run_counter.sv
// Consecutive-event counter: hit fires on the THRESH-th qualifying event and the count restarts.
// clr together with inc restarts the run at one (used for direction reversals).
module adpll_run_counter #(
    parameter int THRESH = 4
) (
    input  logic phase_clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic hit
);

    localparam int W = $clog2(THRESH + 1);
    localparam logic [W-1:0] LAST = W'(THRESH - 1);

    logic [W-1:0] count_r;
    logic [W-1:0] base_s;
    logic [W-1:0] next_s;

    // Next count and threshold detect
    always_comb begin
        base_s = clr ? {W{1'b0}} : count_r;
        hit    = 1'b0;
        next_s = base_s;
        if (inc) begin
            if (base_s == LAST) begin
                hit    = 1'b1;
                next_s = {W{1'b0}};
            end else begin
                next_s = base_s + W'(1);
            end
        end else begin
            next_s = base_s;
        end
    end

    // Count register
    always_ff @(posedge phase_clk or posedge reset) begin
        if (reset) begin
            count_r <= {W{1'b0}};
        end else begin
            count_r <= next_s;
        end
    end

endmodule

// File: rtl/adpll_lock_sequencer.sv
// ADPLL acquisition/lock FSM: binary-search SEARCH, filtered TRACK, LOCKED.
// Optional loss-of-lock re-acquisition is built when LOCK_LOSS_DETECT_EN is defined.
module adpll_lock_sequencer
    import adpll_pkg::*;
#(
    parameter int CODE_W       = DEF_CODE_W,
    parameter int INIT_CODE    = DEF_INIT_CODE,
    parameter int TRACK_THRESH = 4,
`ifdef LOCK_LOSS_DETECT_EN
    parameter int LOSS_CNT     = 16,
`endif
    parameter int LOCK_CNT     = 8
) (
    input  logic              phase_clk,
    input  logic              reset,
    input  logic              start,
    input  logic              p_up,
    input  logic              p_down,
    output logic [CODE_W-1:0] dco_code,
    output logic              freq_lock,
    output logic              phase_lock,
    output logic [1:0]        state,
    output logic              loss_of_lock
);

    localparam logic [CODE_W-1:0] CODE_INIT = CODE_W'(INIT_CODE);
    localparam logic [CODE_W-1:0] CODE_MAX  = {CODE_W{1'b1}};
    localparam logic [CODE_W-1:0] CODE_ZERO = {CODE_W{1'b0}};
    localparam logic [CODE_W-2:0] STEP_INIT = {1'b1, {(CODE_W-2){1'b0}}};
    localparam logic [CODE_W-2:0] STEP_ONE  = {{(CODE_W-2){1'b0}}, 1'b1};

    state_e            state_r, state_s;
    logic [CODE_W-1:0] code_r, code_s;
    logic [CODE_W-2:0] step_r, step_s;
    logic              freq_r, freq_s;
    logic              phase_r, phase_s;

    decision_e         dec_s;
    logic              is_up_s, is_dn_s, is_none_s;
    logic [CODE_W:0]   sum_s;
    logic [CODE_W-1:0] add_code_s, sub_code_s, trk_code_s;
    logic              tracking_s;
    logic              up_inc_s, dn_inc_s, bal_inc_s;
    logic              up_hit_s, dn_hit_s, bal_hit_s;

    assign dec_s     = decode(p_up, p_down);
    assign is_up_s   = (dec_s == UP);
    assign is_dn_s   = (dec_s == DN);
    assign is_none_s = (dec_s == NONE);

    // Saturating binary-search step arithmetic
    assign sum_s      = {1'b0, code_r} + {2'b00, step_r};
    assign add_code_s = sum_s[CODE_W] ? CODE_MAX : sum_s[CODE_W-1:0];
    assign sub_code_s = (code_r < {1'b0, step_r}) ? CODE_ZERO : (code_r - {1'b0, step_r});

    assign tracking_s = (state_r == TRACK) || (state_r == LOCKED);
    assign up_inc_s   = tracking_s && is_up_s;
    assign dn_inc_s   = tracking_s && is_dn_s;
    assign bal_inc_s  = (state_r == TRACK) && is_none_s;

    adpll_run_counter #(.THRESH(TRACK_THRESH)) u_up_cnt (
        .phase_clk (phase_clk),
        .reset     (reset),
        .inc       (up_inc_s),
        .clr       (!up_inc_s),
        .hit       (up_hit_s)
    );

    adpll_run_counter #(.THRESH(TRACK_THRESH)) u_dn_cnt (
        .phase_clk (phase_clk),
        .reset     (reset),
        .inc       (dn_inc_s),
        .clr       (!dn_inc_s),
        .hit       (dn_hit_s)
    );

    adpll_run_counter #(.THRESH(LOCK_CNT)) u_bal_cnt (
        .phase_clk (phase_clk),
        .reset     (reset),
        .inc       (bal_inc_s),
        .clr       (!bal_inc_s),
        .hit       (bal_hit_s)
    );

    // Tracking filter outcome: +-1 on a full run, saturating at both ends
    always_comb begin
        trk_code_s = code_r;
        if (up_hit_s && (code_r != CODE_MAX)) begin
            trk_code_s = code_r + CODE_W'(1);
        end else if (dn_hit_s && (code_r != CODE_ZERO)) begin
            trk_code_s = code_r - CODE_W'(1);
        end else begin
            trk_code_s = code_r;
        end
    end

`ifdef LOCK_LOSS_DETECT_EN
    logic run_inc_s, run_clr_s, run_hit_s, last_up_r, locked_s, reversal_s;

    assign locked_s   = (state_r == LOCKED);
    assign reversal_s = (is_up_s && !last_up_r) || (is_dn_s && last_up_r);
    assign run_inc_s  = locked_s && !is_none_s;
    assign run_clr_s  = !locked_s || is_none_s || reversal_s;

    adpll_run_counter #(.THRESH(LOSS_CNT)) u_run_cnt (
        .phase_clk (phase_clk),
        .reset     (reset),
        .inc       (run_inc_s),
        .clr       (run_clr_s),
        .hit       (run_hit_s)
    );

    // Direction of the last decisive decision seen in LOCKED
    always_ff @(posedge phase_clk or posedge reset) begin
        if (reset) begin
            last_up_r <= 1'b0;
        end else if (run_inc_s) begin
            last_up_r <= is_up_s;
        end else begin
            last_up_r <= last_up_r;
        end
    end
`endif

    logic loss_s;

    // Next-state, code and step decision
    always_comb begin
        state_s = state_r;
        code_s  = code_r;
        step_s  = step_r;
        loss_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = SEARCH;
                    step_s  = STEP_INIT;
                end else begin
                    state_s = IDLE;
                end
            end
            SEARCH: begin
                if (!is_none_s) begin
                    code_s = is_up_s ? add_code_s : sub_code_s;
                    step_s = step_r >> 1;
                    if (step_r == STEP_ONE) begin
                        state_s = TRACK;
                    end else begin
                        state_s = SEARCH;
                    end
                end else begin
                    state_s = SEARCH;
                end
            end
            TRACK: begin
                code_s = trk_code_s;
                if (bal_hit_s) begin
                    state_s = LOCKED;
                end else begin
                    state_s = TRACK;
                end
            end
            LOCKED: begin
`ifdef LOCK_LOSS_DETECT_EN
                if (run_hit_s) begin
                    state_s = SEARCH;
                    step_s  = STEP_INIT;
                    loss_s  = 1'b1;
                end else begin
                    code_s = trk_code_s;
                end
`else
                code_s = trk_code_s;
`endif
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        freq_s  = (state_s == TRACK) || (state_s == LOCKED);
        phase_s = (state_s == LOCKED);
    end

    // Sequencer registers
    always_ff @(posedge phase_clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            code_r  <= CODE_INIT;
            step_r  <= STEP_INIT;
            freq_r  <= 1'b0;
            phase_r <= 1'b0;
        end else begin
            state_r <= state_s;
            code_r  <= code_s;
            step_r  <= step_s;
            freq_r  <= freq_s;
            phase_r <= phase_s;
        end
    end

`ifdef LOCK_LOSS_DETECT_EN
    logic loss_r;

    // Loss-of-lock pulse register
    always_ff @(posedge phase_clk or posedge reset) begin
        if (reset) begin
            loss_r <= 1'b0;
        end else begin
            loss_r <= loss_s;
        end
    end

    assign loss_of_lock = loss_r;
`else
    logic unused_loss_s;
    assign unused_loss_s = loss_s;
    assign loss_of_lock  = 1'b0;
`endif

    assign dco_code   = code_r;
    assign freq_lock  = freq_r;
    assign phase_lock = phase_r;
    assign state      = state_r;

endmodule

// File: tb/tb_adpll_lock_sequencer.sv
// Directed scoreboard bench for adpll_lock_sequencer; a second instance with INIT_CODE=100 covers saturation.
module tb_adpll_lock_sequencer;

    logic       phase_clk;
    logic       reset;
    logic       start;
    logic       p_up;
    logic       p_down;
    logic [6:0] code_a, code_b;
    logic [1:0] state_a, state_b;
    logic       fl_a, fl_b, pl_a, pl_b, lol_a, lol_b;

    int checks = 0;
    int errors = 0;
    int step_no = 0;

    typedef struct {
        logic [6:0] code;
        logic [1:0] st;
        logic       fl;
        logic       pl;
        logic       lol;
        logic       chk2;
        logic [6:0] code2;
        logic [1:0] st2;
    } exp_t;

    exp_t sb[$];

`ifdef LOCK_LOSS_DETECT_EN
    localparam bit LLD = 1'b1;
`else
    localparam bit LLD = 1'b0;
`endif

    adpll_lock_sequencer dut (
        .phase_clk    (phase_clk),
        .reset        (reset),
        .start        (start),
        .p_up         (p_up),
        .p_down       (p_down),
        .dco_code     (code_a),
        .freq_lock    (fl_a),
        .phase_lock   (pl_a),
        .state        (state_a),
        .loss_of_lock (lol_a)
    );

    adpll_lock_sequencer #(.INIT_CODE(100)) dut_hi (
        .phase_clk    (phase_clk),
        .reset        (reset),
        .start        (start),
        .p_up         (p_up),
        .p_down       (p_down),
        .dco_code     (code_b),
        .freq_lock    (fl_b),
        .phase_lock   (pl_b),
        .state        (state_b),
        .loss_of_lock (lol_b)
    );

    initial phase_clk = 1'b0;
    always #5 phase_clk = ~phase_clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s step=%0d observed=%0d expected=%0d", tag, step_no, obs, exp);
        end
    endtask

    task automatic chk_now(input logic [6:0] c, input logic [1:0] st, input logic fl, input logic pl,
                           input logic lol);
        chk("dco_code", {1'b0, code_a}, {1'b0, c});
        chk("state", {6'd0, state_a}, {6'd0, st});
        chk("freq_lock", {7'd0, fl_a}, {7'd0, fl});
        chk("phase_lock", {7'd0, pl_a}, {7'd0, pl});
        chk("loss_of_lock", {7'd0, lol_a}, {7'd0, lol});
    endtask

    // One clock: drive at negedge, push expectation, pop and compare after the edge
    task automatic cyc(input logic s, input logic u, input logic d,
                       input logic [6:0] c, input logic [1:0] st, input logic fl, input logic pl,
                       input logic lol, input logic k2 = 1'b0, input logic [6:0] c2 = 7'd0,
                       input logic [1:0] st2 = 2'd0);
        exp_t e;
        @(negedge phase_clk);
        start  = s;
        p_up   = u;
        p_down = d;
        sb.push_back('{code: c, st: st, fl: fl, pl: pl, lol: lol, chk2: k2, code2: c2, st2: st2});
        @(posedge phase_clk);
        #1;
        step_no++;
        e = sb.pop_front();
        chk_now(e.code, e.st, e.fl, e.pl, e.lol);
        if (e.chk2) begin
            chk("hi_dco_code", {1'b0, code_b}, {1'b0, e.code2});
            chk("hi_state", {6'd0, state_b}, {6'd0, e.st2});
        end
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        p_up   = 1'b0;
        p_down = 1'b0;
        #2;
        chk_now(7'd64, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("hi_reset_code", {1'b0, code_b}, 8'd100);
        @(negedge phase_clk);
        reset = 1'b0;

        // Idle without start
        repeat (10) cyc(1'b0, 1'b0, 1'b0, 7'd64, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 7'd100, 2'd0);

        // Binary search, with NONE, both-high and a stray start interleaved
        cyc(1'b1, 1'b0, 1'b0, 7'd64, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 7'd100, 2'd1);
        cyc(1'b0, 1'b1, 1'b0, 7'd96, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 7'd127, 2'd1);
        repeat (5) cyc(1'b0, 1'b1, 1'b1, 7'd96, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 7'd127, 2'd1);
        cyc(1'b1, 1'b0, 1'b0, 7'd96, 2'd1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 7'd112, 2'd1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 7'd112, 2'd1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 7'd104, 2'd1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 7'd108, 2'd1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 7'd108, 2'd1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 7'd106, 2'd1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 7'd105, 2'd2, 1'b1, 1'b0, 1'b0);

        // Tracking filter: broken run, then a full run
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 7'd105, 2'd2, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 7'd105, 2'd2, 1'b1, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 7'd105, 2'd2, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 7'd106, 2'd2, 1'b1, 1'b0, 1'b0);

        // Phase lock after eight neutral decisions
        repeat (7) cyc(1'b0, 1'b0, 1'b0, 7'd106, 2'd2, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 7'd106, 2'd3, 1'b1, 1'b1, 1'b0);

        // Sustained DN in LOCKED
        for (int i = 1; i <= 16; i++) begin
            if (i == 16 && LLD) begin
                cyc(1'b0, 1'b0, 1'b1, 7'd103, 2'd1, 1'b0, 1'b0, 1'b1);
            end else begin
                cyc(1'b0, 1'b0, 1'b1, 7'(106 - i / 4), 2'd3, 1'b1, 1'b1, 1'b0);
            end
        end
        if (LLD) begin
            cyc(1'b0, 1'b0, 1'b0, 7'd103, 2'd1, 1'b0, 1'b0, 1'b0);
        end else begin
            cyc(1'b0, 1'b0, 1'b0, 7'd102, 2'd3, 1'b1, 1'b1, 1'b0);
        end

        // Async reset from the current state
        @(negedge phase_clk);
        p_up = 1'b0; p_down = 1'b0; start = 1'b0;
        #2 reset = 1'b1;
        #1 chk_now(7'd64, 2'd0, 1'b0, 1'b0, 1'b0);
        @(negedge phase_clk);
        reset = 1'b0;

        // Reset in the middle of SEARCH, then restart
        cyc(1'b1, 1'b0, 1'b0, 7'd64, 2'd1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 7'd96, 2'd1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 7'd112, 2'd1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 7'd120, 2'd1, 1'b0, 1'b0, 1'b0);
        @(negedge phase_clk);
        p_up = 1'b0; p_down = 1'b0; start = 1'b0;
        #2 reset = 1'b1;
        #1 chk_now(7'd64, 2'd0, 1'b0, 1'b0, 1'b0);
        @(negedge phase_clk);
        reset = 1'b0;
        cyc(1'b0, 1'b1, 1'b0, 7'd64, 2'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 7'd64, 2'd1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 7'd96, 2'd1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 7'd80, 2'd1, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adpll_lock_sequencer.md
# adpll_lock_sequencer

Acquisition and lock sequencer for the ADPLL loop. It consumes per-cycle phase-detector decisions (p_up/p_down) and drives the DCO control word through three phases. The first is a binary-search frequency acquisition, the second is counter-filtered fine tracking, and the third is a declared phase lock with optional loss-of-lock re-acquisition. It sits between the PFD and the DCO and replaces ad-hoc step/lock logic with one explicit FSM.

## Interface
- CODE_W, 7: DCO code width; max code = 2^CODE_W-1 (127).
- INIT_CODE, 64: dco_code after reset.
- TRACK_THRESH, 4: consecutive same-direction decisions per ±1 tracking step.
- LOCK_CNT, 8: consecutive neutral decisions to declare phase lock.
- LOSS_CNT, 16: consecutive same-direction decisions in LOCKED that signal loss of lock.

Ports:
- phase_clk  in  1  loop clock, all state on posedge.
- reset  in  1  asynchronous, active-high.
- start  in  1  begin acquisition; sampled only in IDLE.
- p_up  in  1  PFD says DCO too slow.
- p_down  in  1  PFD says DCO too fast.
- dco_code  out  CODE_W  registered DCO control word.
- freq_lock  out  1  high in TRACK and LOCKED.
- phase_lock  out  1  high in LOCKED only.
- state  out  2  IDLE=0, SEARCH=1, TRACK=2, LOCKED=3.
- loss_of_lock  out  1  one-cycle pulse on LOCKED→SEARCH.

## Operation
- Per-cycle decision:
  - UP = p_up & ~p_down.
  - DN = p_down & ~p_up.
  - NONE otherwise, including both high.
- Reset values:
  - dco_code = INIT_CODE.
  - state = IDLE.
  - step = 2^(CODE_W-2) (32).
  - All counters = 0.
  - freq_lock, phase_lock, loss_of_lock = 0.
- IDLE: dco_code holds. start=1 → SEARCH with step = 32.
- SEARCH:
  - UP: code += step, saturating at 127.
  - DN: code -= step, saturating at 0 (code<step → 0).
  - Each UP/DN then halves step. NONE changes nothing.
  - An UP/DN applied with step==1 → TRACK, and freq_lock rises on that edge.
  - SEARCH always takes exactly CODE_W-1 (6) non-NONE decisions.
- TRACK and LOCKED share the tracking filter:
  - up_cnt counts consecutive UP; DN or NONE clears it.
  - dn_cnt mirrors up_cnt for DN.
  - On the TRACK_THRESH-th consecutive UP: code+1 (saturating), up_cnt←0. DN is symmetric.
- TRACK: bal_cnt counts consecutive NONE; any UP/DN clears it. The LOCK_CNT-th consecutive NONE → LOCKED, phase_lock rises.
- LOCKED: tracking continues and phase_lock holds. There is no return to TRACK.
- start is ignored outside IDLE. Only reset returns the block to IDLE.

## Timing
- Decision sampled at posedge N; dco_code, state, and flags update at that same edge and are visible in cycle N+1. No combinational path from p_up/p_down to outputs.
- freq_lock, phase_lock, and state are registered and change on the same edge as the state transition.
- loss_of_lock is high for exactly one cycle, concurrent with state=SEARCH.
- Counter widths are clog2(threshold+1). Counters never wrap because they clear at threshold.
- Async reset mid-operation restores all reset values immediately. The first post-reset edge behaves as IDLE.

## Configuration
- LOCK_LOSS_DETECT_EN defined:
  - In LOCKED, run_cnt counts consecutive same-direction decisions. A reversal sets it to 1; NONE clears it.
  - On the LOSS_CNT-th decision: loss_of_lock pulses, state → SEARCH, step = 32, and freq_lock and phase_lock clear.
  - dco_code keeps its value. The tracking ±1 is suppressed on that edge.
- LOCK_LOSS_DETECT_EN undefined: run_cnt is absent, loss_of_lock is tied 0, and LOCKED is terminal until reset.

## Structure
- Shared package adpll_pkg:
  - State enum (IDLE/SEARCH/TRACK/LOCKED).
  - Decision enum (NONE/UP/DN).
  - Default CODE_W and INIT_CODE constants.
- Sub-module adpll_run_counter: parameterised consecutive-event counter with inc/clr inputs and a hit output at threshold. Instanced for up_cnt, dn_cnt, bal_cnt, and (under the macro) run_cnt.

## Test plan
- Reset, with no start for 10 cycles → dco_code=64, state=0, freq_lock=phase_lock=loss_of_lock=0.
- start, then UP,UP,DN,UP,DN,DN → dco_code 96,112,104,108,106,105; freq_lock=1 and state=2 after the 6th; NONE cycles interleaved do not change code or step.
- INIT_CODE=100, start, UP → dco_code=127 (saturated). Both p_up and p_down high for 5 cycles → no change.
- In TRACK at 105:
  - UP,UP,UP,DN → code unchanged.
  - 4×UP → 106 on the 4th edge.
  - 8×NONE → state=3, phase_lock=1 on the 8th edge.
- LOCKED at 106, 16×DN:
  - With LOCK_LOSS_DETECT_EN: code 103, loss_of_lock pulse, state=1, freq_lock=0.
  - Without the macro: code 102, state stays 3.
- Assert reset during SEARCH after 3 decisions → immediate dco_code=64, state=0. A new start restarts with step 32.
